mac_dot_seq: RTL and testbench
==============================

# mac_dot_seq

Sequencer and datapath for length-N dot products on the 32-bit MAC path. A start command sets a length. The block pulls N multiplicand/multiplier pairs over a valid/ready stream, multiplies them and accumulates them in a pipeline. It then presents the 65-bit sum on a held valid/ready result port. It sits between an operand source (FIFO/DMA) and the result consumer, and replaces free-running MAC accumulation with explicit clear/run/done control.

## Interface
- LEN_W, 16: width of the length field. Maximum vector length is 2^LEN_W-1.
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- len  in  LEN_W  number of operand pairs; latched with start
- busy  out  1  high in every state except IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts a pair this cycle
- multiplicand  in  32  unsigned operand A
- multiplier  in  32  unsigned operand B
- res_valid  out  1  result available; held until accepted
- res_ready  in  1  consumer accepts result
- accumulator_out  out  65  sum of products, modulo 2^65
- overflow  out  1  sticky; a carry out of bit 64 occurred during this job

## Operation
- The FSM has four states:
  - IDLE: in_ready=0, res_valid=0. start=1 latches len, clears the accumulator, overflow and pair counter, and moves to RUN. start while not IDLE is ignored.
  - RUN: in_ready=1 while the accepted count is less than len. A handshake is in_valid&&in_ready on a clock edge. Each handshake registers prod = multiplicand*multiplier (64-bit, unsigned) with prod_vld=1 and increments the count.
  - DRAIN: entered when the count reaches len. in_ready=0. The block waits until prod_vld=0.
  - DONE: res_valid=1 and accumulator_out is stable. res_valid&&res_ready moves the FSM to IDLE on the same edge.
- Accumulate stage: on every edge where prod_vld=1, acc <= acc + {1'b0,prod} mod 2^65. A carry out of bit 64 sets overflow, which stays set until the next start or reset.
- len=0: start goes IDLE to DONE directly. accumulator_out=0, overflow=0.
- accumulator_out and overflow always reflect the internal registers. They are defined as the job result only while res_valid=1.
- Inputs are not consumed in IDLE, DRAIN or DONE. Extra pairs beyond len stay in the source.

## Timing
- Reset value of every output is 0: busy, in_ready, res_valid, accumulator_out, overflow. FSM goes to IDLE, counter=0, prod_vld=0.
- Reset mid-job aborts with no result; the next start begins a fresh job.
- Start to first ready: start sampled at edge E. in_ready=1 from the cycle after E (when len>0).
- Throughput: one pair per cycle. in_ready stays high during in_valid gaps while count<len.
- in_ready is a function of state and counter only; it does not depend on in_valid.
- Result latency: let the last handshake occur in cycle k.
  - prod is registered at the end of cycle k.
  - The accumulate occurs at the end of cycle k+1.
  - res_valid=1 from cycle k+2.
  - So a job of N back-to-back pairs from start edge E gives res_valid at cycle E+N+2.
- Last pair: on the edge where count becomes len, in_ready drops for the following cycle. No (len+1)th pair is ever accepted.
- Simultaneous accumulate and accept: the accumulate of pair i and the capture of pair i+1 happen on the same edge. No stall.
- Result hold: res_valid, accumulator_out and overflow are constant while res_valid&&!res_ready.
- res_ready=1 already on the first DONE cycle gives a one-cycle res_valid pulse. busy drops on the next cycle.
- start asserted on the same edge that leaves DONE is ignored, because the FSM is not yet in IDLE.

## Test plan
- Reset then start, len=2, pairs 0x11111111×0x11111111 twice, back-to-back -> res_valid 4 cycles after start edge, accumulator_out=0x02468ACF0ECA8642, overflow=0.
- len=1, pair 0x12345678×0x87654321, with in_valid held low for 3 cycles first -> accumulator_out=0x09A0CD0570B88D78. in_ready high throughout RUN and low after the handshake.
- len=3, three pairs 0xFFFFFFFF×0xFFFFFFFF -> accumulator_out=0x0FFFFFFFA00000003 (wrapped), overflow=1. Next job, len=1 with 1×1 -> 1 with overflow=0.
- len=0 -> no in_ready pulse, res_valid the cycle after start, accumulator_out=0. Hold res_ready=0 for 5 cycles -> outputs held. Pulse start during DONE -> ignored.
- Assert reset during RUN after 1 of 4 pairs -> all outputs 0 the next cycle. A fresh job with len=1, 2×3 -> 6.
- Drive 5 valid pairs with len=3 -> exactly 3 handshakes, and in_ready=0 from the cycle after the third.

Source files
------------

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequenced length-N dot product on the 32-bit MAC path.
// A start command latches a length. N operand pairs are pulled over a
// valid/ready stream. Each pair goes through a registered multiply stage
// and then a 65-bit accumulate stage. The sum is held on a valid/ready
// result port until the consumer takes it.
module mac_dot_seq #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      multiplicand,
    input  logic [31:0]      multiplier,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [64:0]      accumulator_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] count;
    logic [63:0]      prod;
    logic             prod_vld;
    logic [64:0]      acc;
    logic             ovf;
    logic [65:0]      acc_sum;
    logic             hs;
    logic             clear;

    // Ready depends only on state and count, never on in_valid.
    assign in_ready  = (state == RUN) && (count < len_q);
    assign hs        = in_valid && in_ready;
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);
    assign clear     = (state == IDLE) && start;

    // Bit 65 of the sum is the carry out of the 65-bit accumulator.
    assign acc_sum   = {1'b0, acc} + {2'b00, prod};

    assign accumulator_out = acc;
    assign overflow        = ovf;

    // Job sequencing: length latch, pair counter and state transitions.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            len_q <= '0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        count <= '0;
                        state <= (len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        count <= count + 1'b1;
                        if (count == len_q - 1'b1)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // DRAIN is only entered on the edge that captures the
                    // last product. That product is accumulated on this
                    // edge, and nothing new is captured. So the sum is
                    // final after this edge, and the result can be shown
                    // in the next cycle.
                    state <= DONE;
                end
                DONE: begin
                    if (res_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Multiply stage: register the 64-bit product of each accepted pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod     <= '0;
            prod_vld <= 1'b0;
        end else begin
            prod_vld <= hs;
            if (hs)
                prod <= 64'(multiplicand) * 64'(multiplier);
        end
    end

    // Accumulate stage: wrap modulo 2^65, and keep a sticky flag for any carry-out.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (prod_vld) begin
            acc <= acc_sum[64:0];
            if (acc_sum[65])
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq. It runs the directed scenarios and
// then a set of randomized jobs. Results are compared with a reference
// built from the exact arithmetic sum of the products.
module tb_mac_dot_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        res_valid;
    logic        res_ready;
    logic [64:0] accumulator_out;
    logic        overflow;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [64:0] res_acc;
    logic        res_ovf;

    always #5 clk = ~clk;

    mac_dot_seq #(.LEN_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .len             (len),
        .busy            (busy),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .multiplicand    (multiplicand),
        .multiplier      (multiplier),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .accumulator_out (accumulator_out),
        .overflow        (overflow)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one job using the pairs in qa/qb. lead = idle cycles before the
    // first valid, gap_pct = chance of a bubble, hold = DONE cycles with
    // res_ready low, extra = keep offering pairs after len is reached.
    task automatic run_job(input int n, input int gap_pct, input int lead,
                           input int hold, input bit extra);
        logic [127:0] total;
        logic [64:0]  exp_acc;
        logic         exp_ovf;
        int idx, edge_n, last_hs;
        bit hs;
        total = '0;
        for (int i = 0; i < n; i++)
            total += 128'(qa[i]) * 128'(qb[i]);
        exp_acc = total[64:0];
        exp_ovf = |total[127:65];

        start = 1'b1; len = 16'(n);
        tick();
        start = 1'b0; len = '0;
        chk("busy_after_start", busy, 1);
        idx = 0; edge_n = 0; last_hs = 0;
        while (!res_valid && edge_n < 2000) begin
            chk("in_ready_run", in_ready, (idx < n));
            if (idx < n) begin
                in_valid     = (edge_n >= lead) && ($urandom_range(99) >= gap_pct);
                multiplicand = qa[idx];
                multiplier   = qb[idx];
            end else begin
                in_valid     = extra;
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            hs = in_valid && in_ready;
            tick();
            edge_n++;
            if (hs) begin
                idx++;
                last_hs = edge_n;
            end
        end
        in_valid = 1'b0;
        if (!res_valid) begin
            chk("res_timeout", 0, 1);
            return;
        end
        chk("handshakes", idx, n);
        chk("latency", edge_n, (n == 0) ? 0 : last_hs + 1);
        chk("acc", accumulator_out, exp_acc);
        chk("ovf", overflow, exp_ovf);
        chk("in_ready_done", in_ready, 0);
        res_acc = accumulator_out;
        res_ovf = overflow;

        res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            start = (h == 1);
            len   = 16'd3;
            tick();
            start = 1'b0;
            chk("hold_valid", res_valid, 1);
            chk("hold_acc", accumulator_out, exp_acc);
            chk("hold_ovf", overflow, exp_ovf);
        end
        // Accept the result while start is high. That start must be ignored.
        res_ready = 1'b1; start = 1'b1; len = 16'd5;
        tick();
        res_ready = 1'b0; start = 1'b0; len = '0;
        chk("post_valid", res_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_ready", in_ready, 0);
    endtask

    task automatic set_pairs(input int n, input logic [31:0] a, input logic [31:0] b);
        qa.delete(); qb.delete();
        for (int i = 0; i < n; i++) begin
            qa.push_back(a);
            qb.push_back(b);
        end
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        multiplicand = '0; multiplier = '0; res_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_acc", accumulator_out, 0);
        chk("rst_ovf", overflow, 0);

        // Two back-to-back pairs.
        set_pairs(2, 32'h11111111, 32'h11111111);
        run_job(2, 0, 0, 0, 1'b0);
        chk("t1_acc", res_acc, 65'h0_02468ACF0ECA8642);
        chk("t1_ovf", res_ovf, 0);

        // A single pair that arrives after three idle cycles.
        set_pairs(1, 32'h12345678, 32'h87654321);
        run_job(1, 0, 3, 1, 1'b0);
        chk("t2_acc", res_acc, 65'h0_09A0CD0570B88D78);

        // The sum wraps and overflow sets. It is cleared for the next job.
        set_pairs(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_job(3, 0, 0, 0, 1'b0);
        chk("t3_acc", res_acc, 65'h0_FFFFFFFA00000003);
        chk("t3_ovf", res_ovf, 1);
        set_pairs(1, 32'd1, 32'd1);
        run_job(1, 0, 0, 0, 1'b0);
        chk("t3b_acc", res_acc, 65'd1);
        chk("t3b_ovf", res_ovf, 0);

        // len = 0, with the result held for 5 cycles and start pulsed in DONE.
        qa.delete(); qb.delete();
        run_job(0, 0, 0, 5, 1'b1);
        chk("t4_acc", res_acc, 0);

        // Reset in the middle of a job, after 1 of 4 pairs.
        start = 1'b1; len = 16'd4;
        tick();
        start = 1'b0;
        in_valid = 1'b1; multiplicand = 32'd7; multiplier = 32'd9;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_acc", accumulator_out, 0);
        chk("mid_rst_ovf", overflow, 0);
        set_pairs(1, 32'd2, 32'd3);
        run_job(1, 0, 0, 0, 1'b0);
        chk("t5_acc", res_acc, 65'd6);

        // Extra pairs after len are offered but not taken.
        qa.delete(); qb.delete();
        for (int i = 0; i < 5; i++) begin
            qa.push_back($urandom);
            qb.push_back($urandom);
        end
        run_job(3, 0, 0, 0, 1'b1);

        // Randomized jobs, with bubbles and saturated operands.
        for (int j = 0; j < 30; j++) begin
            n = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 12));
            if (j == 29) n = 40;
            qa.delete(); qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(($urandom_range(3) == 0 || j == 29) ? 32'hFFFFFFFF : $urandom);
                qb.push_back(($urandom_range(3) == 0 || j == 29) ? 32'hFFFFFFFF : $urandom);
            end
            run_job(n, int'($urandom_range(0, 40)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), 1'($urandom_range(1)));
        end
        chk("big_ovf", res_ovf, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
